// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle RV32I control unit, FETCH/DECODE/EXEC/MEM/WB plus TRAP.
// Latency with zero-wait memory: ALU/jump 4 cycles, branch 3, store 4, load 5.
// Backpressure: holds mem_req until mem_ack, at most MEM_TIMEOUT cycles, then bus-error trap.
// Optional build macro CTRL_ILLEGAL_TRAP_EN: unrecognised opcodes trap instead of running as NOP.
module ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int ALU_OP_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          opcode,
  input  logic [2:0]          func3,
  input  logic [6:0]          func7,
  input  logic                b,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic [2:0]          mem_size,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          pc_sel,
  output logic                rf_we,
  output logic [2:0]          imm_type,
  output logic                alu1_sel,
  output logic                alu2_sel,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [2:0]          state,
  output logic                bus_err,
  output logic                illegal
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  // Instruction class remembered from DECODE to steer EXEC/MEM/WB.
  typedef enum logic [2:0] {
    CLS_ALU  = 3'd0,
    CLS_JAL  = 3'd1,
    CLS_JALR = 3'd2,
    CLS_BR   = 3'd3,
    CLS_LD   = 3'd4,
    CLS_ST   = 3'd5,
    CLS_ILL  = 3'd6
  } cls_t;

  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  localparam logic [2:0] IMM_NONE = 3'b000;
  localparam logic [2:0] IMM_U    = 3'b001;
  localparam logic [2:0] IMM_J    = 3'b010;
  localparam logic [2:0] IMM_S    = 3'b011;
  localparam logic [2:0] IMM_I    = 3'b100;
  localparam logic [2:0] IMM_B    = 3'b101;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_AND  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_ALU   = 2'd1;
  localparam logic [1:0] PC_ALUE  = 2'd2;
  localparam logic [1:0] PC_TRAP  = 2'd3;

  state_t               state_q;
  cls_t                 cls_q;
  logic [7:0]           cnt_q;
  logic                 bus_err_q;
  logic [2:0]           imm_q;
  logic                 a1_q;
  logic                 a2_q;
  logic [ALU_OP_W-1:0]  alu_op_q;
  logic [2:0]           size_q;

  cls_t                 d_cls;
  logic [2:0]           d_imm;
  logic                 d_a1;
  logic                 d_a2;
  logic [3:0]           d_op;
  logic [3:0]           f3_op;
  logic                 timeout;

  // Last waiting cycle: the request has been outstanding for MEM_TIMEOUT cycles.
  // An ack arriving in this same cycle still completes normally.
  assign timeout = (cnt_q == 8'(MEM_TIMEOUT - 1)) && !mem_ack;

  // Combinational decode of the instruction register fields; sampled only in DECODE.
  always_comb begin
    d_cls = CLS_ILL;
    d_imm = IMM_NONE;
    d_a1  = 1'b0;
    d_a2  = 1'b1;
    d_op  = ALU_ADD;
    case (func3)
      3'b000:  f3_op = (opcode == OPC_OP && func7 == F7_ALT) ? ALU_SUB : ALU_ADD;
      3'b001:  f3_op = ALU_SLL;
      3'b010:  f3_op = ALU_SLT;
      3'b011:  f3_op = ALU_SLTU;
      3'b100:  f3_op = ALU_XOR;
      3'b101:  f3_op = (func7 == F7_ALT) ? ALU_SRA : ALU_SRL;
      3'b110:  f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
    case (opcode)
      OPC_LUI:    begin d_cls = CLS_ALU;  d_imm = IMM_U; d_op = ALU_PASS; end
      OPC_AUIPC:  begin d_cls = CLS_ALU;  d_imm = IMM_U; d_a1 = 1'b1; end
      OPC_JAL:    begin d_cls = CLS_JAL;  d_imm = IMM_J; d_a1 = 1'b1; end
      OPC_JALR:   begin d_cls = CLS_JALR; d_imm = IMM_I; end
      OPC_BRANCH: begin d_cls = CLS_BR;   d_imm = IMM_B; d_a1 = 1'b1; end
      OPC_LOAD:   begin d_cls = CLS_LD;   d_imm = IMM_I; end
      OPC_STORE:  begin d_cls = CLS_ST;   d_imm = IMM_S; end
      OPC_OPIMM:  begin d_cls = CLS_ALU;  d_imm = IMM_I; d_op = f3_op; end
      OPC_OP:     begin d_cls = CLS_ALU;  d_a2 = 1'b0;   d_op = f3_op; end
      default:    ;
    endcase
  end

  // Sequencer: state, decoded control registers, request timeout and sticky bus error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      cls_q     <= CLS_ALU;
      cnt_q     <= 8'd0;
      bus_err_q <= 1'b0;
      imm_q     <= IMM_NONE;
      a1_q      <= 1'b0;
      a2_q      <= 1'b0;
      alu_op_q  <= '0;
      size_q    <= 3'd0;
    end else begin
      cnt_q <= 8'd0;
      case (state_q)
        FETCH: begin
          if (mem_ack) begin
            state_q <= DECODE;
          end else if (timeout) begin
            state_q   <= TRAP;
            bus_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DECODE: begin
          cls_q    <= d_cls;
          imm_q    <= d_imm;
          a1_q     <= d_a1;
          a2_q     <= d_a2;
          alu_op_q <= ALU_OP_W'(d_op);
          size_q   <= func3;
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_q  <= (d_cls == CLS_ILL) ? TRAP : EXEC;
`else
          state_q  <= EXEC;
`endif
        end
        EXEC: begin
          case (cls_q)
            CLS_BR:          state_q <= FETCH;
            CLS_LD, CLS_ST:  state_q <= MEM;
            default:         state_q <= WB;
          endcase
        end
        MEM: begin
          if (mem_ack) begin
            state_q <= (cls_q == CLS_ST) ? FETCH : WB;
          end else if (timeout) begin
            state_q   <= TRAP;
            bus_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        WB:      state_q <= FETCH;
        TRAP:    state_q <= FETCH;
        default: state_q <= FETCH;
      endcase
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic ill_q;

  // Remember that the pending TRAP came from DECODE rather than a bus timeout.
  always_ff @(posedge clk) begin
    if (rst) ill_q <= 1'b0;
    else     ill_q <= (state_q == DECODE) && (d_cls == CLS_ILL);
  end

  assign illegal = !rst && (state_q == TRAP) && ill_q;
`else
  assign illegal = 1'b0;
`endif

  // Per-state strobes; ir_we follows mem_ack in FETCH, everything is quiet while rst is high.
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_sel  = PC_PLUS4;
    rf_we   = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ack;
        end
        EXEC: begin
          if (cls_q == CLS_BR) begin
            pc_we  = 1'b1;
            pc_sel = b ? PC_ALU : PC_PLUS4;
          end
        end
        MEM: begin
          mem_req = 1'b1;
          mem_we  = (cls_q == CLS_ST);
          pc_we   = mem_ack && (cls_q == CLS_ST);
        end
        WB: begin
          rf_we = (cls_q != CLS_ILL);
          pc_we = 1'b1;
          if (cls_q == CLS_JAL)       pc_sel = PC_ALU;
          else if (cls_q == CLS_JALR) pc_sel = PC_ALUE;
        end
        TRAP: begin
          pc_we  = 1'b1;
          pc_sel = PC_TRAP;
        end
        default: ;
      endcase
    end
  end

  assign state    = state_q;
  assign bus_err  = bus_err_q;
  assign imm_type = imm_q;
  assign alu1_sel = a1_q;
  assign alu2_sel = a2_q;
  assign alu_op   = alu_op_q;
  assign mem_size = size_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: directed checks of the multi-cycle control sequencer.
// Inputs change 2ns after the rising edge, outputs are sampled 1ns later.
// The illegal-opcode scenario follows whichever build of CTRL_ILLEGAL_TRAP_EN is compiled.
module tb_ctrl_fsm;

  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_BAD    = 5'b10101;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       b;
  logic       mem_ack;
  logic       mem_req, mem_we, ir_we, pc_we, rf_we, alu1_sel, alu2_sel, bus_err, illegal;
  logic [2:0] mem_size, imm_type, state;
  logic [1:0] pc_sel;
  logic [3:0] alu_op;

  int n_cmp = 0;
  int n_err = 0;

  ctrl_fsm #(.MEM_TIMEOUT(15), .ALU_OP_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7), .b(b),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .imm_type(imm_type),
    .alu1_sel(alu1_sel), .alu2_sel(alu2_sel), .alu_op(alu_op), .state(state),
    .bus_err(bus_err), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // From FETCH: present the instruction with a zero-wait ack, leave the FSM in EXEC.
  task automatic fetch(input logic [4:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op; func3 = f3; func7 = f7;
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ack = 1'b1; b = 1'b0;
    opcode = OPC_OP; func3 = 3'b000; func7 = F7_ZERO;
    cyc(); cyc();
    #1;
    n_cmp++; if (state !== 3'd0)    begin n_err++; $display("FAIL reset.state got=%0d exp=0", state); end
    n_cmp++; if (mem_req !== 1'b0)  begin n_err++; $display("FAIL reset.mem_req got=%b exp=0", mem_req); end
    n_cmp++; if (ir_we !== 1'b0)    begin n_err++; $display("FAIL reset.ir_we got=%b exp=0", ir_we); end
    n_cmp++; if (pc_we !== 1'b0 || rf_we !== 1'b0) begin n_err++; $display("FAIL reset.strobes got pc_we=%b rf_we=%b exp=0,0", pc_we, rf_we); end
    n_cmp++; if (bus_err !== 1'b0)  begin n_err++; $display("FAIL reset.bus_err got=%b exp=0", bus_err); end
    n_cmp++; if ({alu_op, imm_type, alu1_sel, alu2_sel, mem_size} !== 13'd0) begin n_err++; $display("FAIL reset.decode_regs got op=%0d imm=%0d a1=%b a2=%b size=%0d exp=all 0", alu_op, imm_type, alu1_sel, alu2_sel, mem_size); end
    mem_ack = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b1)  begin n_err++; $display("FAIL reset.first_req got=%b exp=1", mem_req); end
  endtask

  task automatic test_op_add();
    opcode = OPC_OP; func3 = 3'b000; func7 = F7_ZERO;
    mem_ack = 1'b1;
    #1;
    n_cmp++; if (ir_we !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b0) begin n_err++; $display("FAIL op_add.fetch got ir_we=%b req=%b we=%b exp=1,1,0", ir_we, mem_req, mem_we); end
    cyc(); mem_ack = 1'b0; #1;
    n_cmp++; if (state !== 3'd1 || ir_we !== 1'b0 || mem_req !== 1'b0) begin n_err++; $display("FAIL op_add.decode got state=%0d ir_we=%b req=%b exp=1,0,0", state, ir_we, mem_req); end
    cyc(); #1;
    n_cmp++; if (state !== 3'd2 || alu_op !== 4'd0 || alu2_sel !== 1'b0 || imm_type !== 3'd0) begin n_err++; $display("FAIL op_add.exec got state=%0d op=%0d a2=%b imm=%0d exp=2,0,0,0", state, alu_op, alu2_sel, imm_type); end
    n_cmp++; if (rf_we !== 1'b0 || pc_we !== 1'b0) begin n_err++; $display("FAIL op_add.exec_strobes got rf_we=%b pc_we=%b exp=0,0", rf_we, pc_we); end
    cyc(); #1;
    n_cmp++; if (state !== 3'd4 || rf_we !== 1'b1 || pc_we !== 1'b1 || pc_sel !== 2'd0) begin n_err++; $display("FAIL op_add.wb got state=%0d rf_we=%b pc_we=%b sel=%0d exp=4,1,1,0", state, rf_we, pc_we, pc_sel); end
    cyc(); #1;
    n_cmp++; if (state !== 3'd0 || rf_we !== 1'b0 || pc_we !== 1'b0) begin n_err++; $display("FAIL op_add.back got state=%0d rf_we=%b pc_we=%b exp=0,0,0", state, rf_we, pc_we); end
  endtask

  // Row: {opcode, func3, func7, alu_op, imm_type, alu1_sel, alu2_sel, pc_sel in WB}
  task automatic test_decode();
    logic [25:0] tbl [13];
    logic [25:0] r;
    tbl[0]  = {OPC_OP,    3'b000, F7_ALT,  4'd1,  3'd0, 1'b0, 1'b0, 2'd0};
    tbl[1]  = {OPC_OPIMM, 3'b101, F7_ALT,  4'd9,  3'd4, 1'b0, 1'b1, 2'd0};
    tbl[2]  = {OPC_OPIMM, 3'b000, F7_ALT,  4'd0,  3'd4, 1'b0, 1'b1, 2'd0};
    tbl[3]  = {OPC_OP,    3'b101, F7_ZERO, 4'd8,  3'd0, 1'b0, 1'b0, 2'd0};
    tbl[4]  = {OPC_OP,    3'b011, F7_ZERO, 4'd3,  3'd0, 1'b0, 1'b0, 2'd0};
    tbl[5]  = {OPC_OPIMM, 3'b110, F7_ZERO, 4'd5,  3'd4, 1'b0, 1'b1, 2'd0};
    tbl[6]  = {OPC_OP,    3'b111, F7_ZERO, 4'd6,  3'd0, 1'b0, 1'b0, 2'd0};
    tbl[7]  = {OPC_OP,    3'b001, F7_ZERO, 4'd7,  3'd0, 1'b0, 1'b0, 2'd0};
    tbl[8]  = {OPC_OP,    3'b100, F7_ZERO, 4'd4,  3'd0, 1'b0, 1'b0, 2'd0};
    tbl[9]  = {OPC_LUI,   3'b101, F7_ALT,  4'd10, 3'd1, 1'b0, 1'b1, 2'd0};
    tbl[10] = {OPC_AUIPC, 3'b010, F7_ZERO, 4'd0,  3'd1, 1'b1, 1'b1, 2'd0};
    tbl[11] = {OPC_JAL,   3'b111, F7_ALT,  4'd0,  3'd2, 1'b1, 1'b1, 2'd1};
    tbl[12] = {OPC_JALR,  3'b000, F7_ZERO, 4'd0,  3'd4, 1'b0, 1'b1, 2'd2};
    for (int i = 0; i < 13; i++) begin
      r = tbl[i];
      fetch(r[25:21], r[20:18], r[17:11]);
      #1;
      n_cmp++; if (state !== 3'd2 || alu_op !== r[10:7]) begin n_err++; $display("FAIL decode[%0d].alu_op got state=%0d op=%0d exp=2,%0d", i, state, alu_op, r[10:7]); end
      n_cmp++; if (imm_type !== r[6:4] || alu1_sel !== r[3] || alu2_sel !== r[2]) begin n_err++; $display("FAIL decode[%0d].sel got imm=%0d a1=%b a2=%b exp=%0d,%b,%b", i, imm_type, alu1_sel, alu2_sel, r[6:4], r[3], r[2]); end
      cyc(); #1;
      n_cmp++; if (state !== 3'd4 || rf_we !== 1'b1 || pc_we !== 1'b1 || pc_sel !== r[1:0]) begin n_err++; $display("FAIL decode[%0d].wb got state=%0d rf_we=%b pc_we=%b sel=%0d exp=4,1,1,%0d", i, state, rf_we, pc_we, pc_sel, r[1:0]); end
      cyc();
    end
  endtask

  task automatic test_branch();
    fetch(OPC_BRANCH, 3'b000, F7_ZERO);
    b = 1'b1; #1;
    n_cmp++; if (state !== 3'd2 || pc_we !== 1'b1 || pc_sel !== 2'd1 || imm_type !== 3'd5 || alu1_sel !== 1'b1) begin n_err++; $display("FAIL branch_taken got state=%0d pc_we=%b sel=%0d imm=%0d a1=%b exp=2,1,1,5,1", state, pc_we, pc_sel, imm_type, alu1_sel); end
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL branch_taken.rf_we got=%b exp=0", rf_we); end
    cyc(); b = 1'b0; #1;
    n_cmp++; if (state !== 3'd0 || pc_we !== 1'b0) begin n_err++; $display("FAIL branch_taken.next got state=%0d pc_we=%b exp=0,0", state, pc_we); end
    fetch(OPC_BRANCH, 3'b001, F7_ZERO);
    #1;
    n_cmp++; if (state !== 3'd2 || pc_we !== 1'b1 || pc_sel !== 2'd0) begin n_err++; $display("FAIL branch_not_taken got state=%0d pc_we=%b sel=%0d exp=2,1,0", state, pc_we, pc_sel); end
    cyc(); #1;
    n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL branch_not_taken.next got state=%0d exp=0", state); end
  endtask

  task automatic test_load_store();
    fetch(OPC_LOAD, 3'b010, F7_ZERO);
    #1;
    n_cmp++; if (state !== 3'd2 || mem_req !== 1'b0 || imm_type !== 3'd4 || mem_size !== 3'd2) begin n_err++; $display("FAIL load.exec got state=%0d req=%b imm=%0d size=%0d exp=2,0,4,2", state, mem_req, imm_type, mem_size); end
    cyc();
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3); #1;
      n_cmp++; if (state !== 3'd3 || mem_req !== 1'b1 || mem_we !== 1'b0 || rf_we !== 1'b0 || pc_we !== 1'b0) begin n_err++; $display("FAIL load.mem[%0d] got state=%0d req=%b we=%b rf_we=%b pc_we=%b exp=3,1,0,0,0", i, state, mem_req, mem_we, rf_we, pc_we); end
      cyc();
    end
    mem_ack = 1'b0; #1;
    n_cmp++; if (state !== 3'd4 || rf_we !== 1'b1 || pc_we !== 1'b1 || pc_sel !== 2'd0 || mem_req !== 1'b0) begin n_err++; $display("FAIL load.wb got state=%0d rf_we=%b pc_we=%b sel=%0d req=%b exp=4,1,1,0,0", state, rf_we, pc_we, pc_sel, mem_req); end
    cyc();
    fetch(OPC_STORE, 3'b001, F7_ZERO);
    #1;
    n_cmp++; if (state !== 3'd2 || imm_type !== 3'd3 || mem_size !== 3'd1 || alu2_sel !== 1'b1) begin n_err++; $display("FAIL store.exec got state=%0d imm=%0d size=%0d a2=%b exp=2,3,1,1", state, imm_type, mem_size, alu2_sel); end
    cyc(); #1;
    n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || pc_we !== 1'b0) begin n_err++; $display("FAIL store.wait got req=%b we=%b pc_we=%b exp=1,1,0", mem_req, mem_we, pc_we); end
    cyc(); mem_ack = 1'b1; #1;
    n_cmp++; if (state !== 3'd3 || pc_we !== 1'b1 || pc_sel !== 2'd0 || rf_we !== 1'b0) begin n_err++; $display("FAIL store.ack got state=%0d pc_we=%b sel=%0d rf_we=%b exp=3,1,0,0", state, pc_we, pc_sel, rf_we); end
    cyc(); mem_ack = 1'b0; #1;
    n_cmp++; if (state !== 3'd0 || pc_we !== 1'b0 || rf_we !== 1'b0) begin n_err++; $display("FAIL store.next got state=%0d pc_we=%b rf_we=%b exp=0,0,0", state, pc_we, rf_we); end
  endtask

  task automatic test_ack_at_limit();
    opcode = OPC_OP; func3 = 3'b000; func7 = F7_ZERO; mem_ack = 1'b0;
    for (int i = 0; i < 14; i++) cyc();
    mem_ack = 1'b1; #1;
    n_cmp++; if (state !== 3'd0 || mem_req !== 1'b1 || ir_we !== 1'b1) begin n_err++; $display("FAIL ack_limit.fetch got state=%0d req=%b ir_we=%b exp=0,1,1", state, mem_req, ir_we); end
    cyc(); mem_ack = 1'b0; #1;
    n_cmp++; if (state !== 3'd1 || bus_err !== 1'b0) begin n_err++; $display("FAIL ack_limit.decode got state=%0d bus_err=%b exp=1,0", state, bus_err); end
    cyc(); cyc(); cyc();
  endtask

  task automatic test_timeout();
    mem_ack = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      n_cmp++; if (state !== 3'd0 || mem_req !== 1'b1 || bus_err !== 1'b0) begin n_err++; $display("FAIL timeout.wait[%0d] got state=%0d req=%b bus_err=%b exp=0,1,0", i, state, mem_req, bus_err); end
      cyc();
    end
    #1;
    n_cmp++; if (state !== 3'd7 || mem_req !== 1'b0 || bus_err !== 1'b1) begin n_err++; $display("FAIL timeout.trap got state=%0d req=%b bus_err=%b exp=7,0,1", state, mem_req, bus_err); end
    n_cmp++; if (pc_we !== 1'b1 || pc_sel !== 2'd3 || illegal !== 1'b0) begin n_err++; $display("FAIL timeout.trap_pc got pc_we=%b sel=%0d illegal=%b exp=1,3,0", pc_we, pc_sel, illegal); end
    cyc(); #1;
    n_cmp++; if (state !== 3'd0 || bus_err !== 1'b1) begin n_err++; $display("FAIL timeout.sticky got state=%0d bus_err=%b exp=0,1", state, bus_err); end
    rst = 1'b1;
    cyc(); #1;
    n_cmp++; if (bus_err !== 1'b0 || mem_req !== 1'b0) begin n_err++; $display("FAIL timeout.rst_clear got bus_err=%b req=%b exp=0,0", bus_err, mem_req); end
    rst = 1'b0;
  endtask

  task automatic test_rst_abort();
    fetch(OPC_OP, 3'b100, F7_ZERO);
    cyc();
    rst = 1'b1; #1;
    n_cmp++; if (rf_we !== 1'b0 || pc_we !== 1'b0) begin n_err++; $display("FAIL rst_abort.wb got rf_we=%b pc_we=%b exp=0,0", rf_we, pc_we); end
    cyc(); #1;
    n_cmp++; if (state !== 3'd0 || mem_req !== 1'b0 || rf_we !== 1'b0 || pc_we !== 1'b0) begin n_err++; $display("FAIL rst_abort.held got state=%0d req=%b rf_we=%b pc_we=%b exp=0,0,0,0", state, mem_req, rf_we, pc_we); end
    rst = 1'b0; #1;
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rst_abort.restart got req=%b exp=1", mem_req); end
  endtask

  task automatic test_illegal();
    opcode = OPC_BAD; func3 = 3'b000; func7 = F7_ZERO;
    mem_ack = 1'b1;
    cyc(); mem_ack = 1'b0;
    cyc(); #1;
`ifdef CTRL_ILLEGAL_TRAP_EN
    n_cmp++; if (state !== 3'd7 || illegal !== 1'b1 || pc_we !== 1'b1 || pc_sel !== 2'd3) begin n_err++; $display("FAIL illegal.trap got state=%0d illegal=%b pc_we=%b sel=%0d exp=7,1,1,3", state, illegal, pc_we, pc_sel); end
    cyc(); #1;
    n_cmp++; if (state !== 3'd0 || illegal !== 1'b0) begin n_err++; $display("FAIL illegal.next got state=%0d illegal=%b exp=0,0", state, illegal); end
`else
    n_cmp++; if (state !== 3'd2 || illegal !== 1'b0) begin n_err++; $display("FAIL illegal.nop_exec got state=%0d illegal=%b exp=2,0", state, illegal); end
    cyc(); #1;
    n_cmp++; if (state !== 3'd4 || rf_we !== 1'b0 || pc_we !== 1'b1 || pc_sel !== 2'd0) begin n_err++; $display("FAIL illegal.nop_wb got state=%0d rf_we=%b pc_we=%b sel=%0d exp=4,0,1,0", state, rf_we, pc_we, pc_sel); end
    cyc(); #1;
    n_cmp++; if (state !== 3'd0 || illegal !== 1'b0) begin n_err++; $display("FAIL illegal.next got state=%0d illegal=%b exp=0,0", state, illegal); end
`endif
  endtask

  initial begin
    test_reset();
    test_op_add();
    test_decode();
    test_branch();
    test_load_store();
    test_ack_at_limit();
    test_timeout();
    test_rst_abort();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_fsm.md
# ctrl_fsm

Multi-cycle control unit for the RV32I core; successor to the single-cycle `ctrl` decoder. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with a req/ack handshake to instruction/data memory and a parametrised bus timeout. Drives the immediate, ALU-operand, ALU-op, PC, register-file and memory controls of the datapath. Sits between the instruction register and the datapath muxes.

## Interface
- `MEM_TIMEOUT`, 15: maximum cycles a memory request may wait for `mem_ack` before bus-error trap (1..255).
- `ALU_OP_W`, 4: width of `alu_op`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `opcode` in 5: instr[6:2].
- `func3` in 3: instr[14:12].
- `func7` in 7: instr[31:25].
- `b` in 1: branch comparator result from datapath, valid in EXEC.
- `mem_ack` in 1: memory completes current request this cycle.
- `mem_req` out 1: memory request active.
- `mem_we` out 1: request is a write (store).
- `mem_size` out 3: func3 of current load/store.
- `ir_we` out 1: latch instruction register.
- `pc_we` out 1: update PC.
- `pc_sel` out 2: 0 pc+4, 1 ALU result, 2 ALU result & ~1, 3 trap vector.
- `rf_we` out 1: register-file write.
- `imm_type` out 3: 000 none, 001 U, 010 J, 011 S, 100 I, 101 B.
- `alu1_sel` out 1: 1 = PC, 0 = rs1.
- `alu2_sel` out 1: 0 = rs2, 1 = immediate.
- `alu_op` out `ALU_OP_W`: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 OR, 6 AND, 7 SLL, 8 SRL, 9 SRA, 10 PASS_B.
- `state` out 3: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 7.
- `bus_err` out 1: sticky, set on timeout; cleared by reset only.
- `illegal` out 1: one-cycle pulse in TRAP caused by illegal opcode.

## Operation
- FETCH: `mem_req`=1, `mem_we`=0. On `mem_ack`: `ir_we`=1 same cycle (Mealy), next DECODE.
- DECODE (1 cycle): register `imm_type`, `alu1_sel`, `alu2_sel`, `alu_op`, `mem_size` from opcode/func3/func7; held until next DECODE.
- Decode rules: LUI U/PASS_B; AUIPC(00101) U/alu1=1/ADD; JAL J/alu1=1/ADD; JALR I/ADD; BRANCH B/alu1=1/ADD; LOAD I/ADD; STORE S/ADD; OP_IMM I, func3-mapped op; OP alu2_sel=0, func3-mapped op. alu2_sel=0 only for OP.
- func3 map: 000 ADD (SUB if OP and func7=0100000), 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND, 001 SLL, 101 SRL (SRA if func7=0100000).
- EXEC (1 cycle): BRANCH -> `pc_we`=1, `pc_sel`=b?1:0, next FETCH. LOAD/STORE -> MEM. Other legal -> WB.
- MEM: `mem_req`=1, `mem_we`=1 for STORE. On ack: STORE -> `pc_we`=1, `pc_sel`=0, next FETCH; LOAD -> WB.
- WB (1 cycle): `rf_we`=1, `pc_we`=1; `pc_sel`=1 for JAL, 2 for JALR, else 0; next FETCH.
- TRAP (1 cycle): `pc_we`=1, `pc_sel`=3, next FETCH.
- Timeout counter: cleared on entry to FETCH/MEM, increments each cycle without ack; reaching `MEM_TIMEOUT` without ack -> `mem_req` drops, `bus_err`=1, next TRAP. Ack on the same cycle the count reaches the limit wins.

## Timing
- Reset (`rst`=1 at edge): state FETCH, decoded registers 0, counter 0, `bus_err`=0; all strobes 0 while `rst` high. First `mem_req` the cycle after `rst` falls.
- Latency with zero-wait ack: ALU/jump 4 cycles, branch 3, store 4, load 5.
- `rst` mid-instruction aborts: no `rf_we`/`pc_we` issued afterwards; pending request dropped.
- Strobes `ir_we`, `pc_we`, `rf_we` are single-cycle pulses.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined: unrecognised opcode in DECODE -> TRAP, `illegal` pulses 1 in TRAP.
- Undefined: unrecognised opcode executes as NOP (EXEC then WB with `rf_we`=0, `pc_sel`=0); `illegal` tied 0. Bus-timeout TRAP exists in both builds.

## Test plan
- Reset then OP ADD (func7 0), ack next cycle -> states 0,1,2,4,0; `alu_op`=0, `alu2_sel`=0, `rf_we` pulse in WB.
- OP func3=000 func7=0100000 -> `alu_op`=1; OP_IMM func3=101 func7=0100000 -> `alu_op`=9, `alu2_sel`=1, `imm_type`=100.
- BRANCH with b=1 -> EXEC `pc_we`=1, `pc_sel`=1, `imm_type`=101; b=0 -> `pc_sel`=0; no WB visit.
- LOAD with 3-cycle ack delay in MEM -> `mem_req` held 4 cycles, `mem_we`=0, then WB `rf_we`=1; STORE -> `mem_we`=1, `pc_we` on ack, no `rf_we`.
- No ack in FETCH for 15 cycles -> `bus_err`=1, TRAP with `pc_sel`=3; `rst` pulse clears `bus_err`.
- opcode 10101 -> with macro: TRAP, `illegal`=1; without: NOP, PC+4, `rf_we`=0.
